// File: rtl/split_12_sampler_if.sv
// Sample delivery channel: valid/ready handshake plus the two sampled variables.
//   out_valid : producer presents a sample
//   out_ready : consumer accepts the sample
//   var_20    : sampled var_20
//   var_41    : sampled var_41
interface split_12_sampler_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] var_20;
  logic [7:0] var_41;

  modport master (output out_valid, output var_20, output var_41, input out_ready);
  modport slave  (input out_valid, input var_20, input var_41, output out_ready);
endinterface

// File: rtl/split_12_sampler.sv
// Rejection-sampling generator for the split_12 constraint group.
// Draws (var_20, var_41) candidates from a Galois LFSR, keeps only those with
// var_20 != 0, and presents them over a valid/ready channel.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   seed_load/seed_in : reseed LFSR (IDLE only; zero seed maps to SEED)
//   start             : request one satisfying sample
//   bus (master)      : out_valid/out_ready/var_20/var_41
//   tries             : rejected candidates for current/last request
//   busy              : high in GEN, CHECK, HOLD
//   fail              : sticky, MAX_TRIES candidates rejected
module split_12_sampler #(
  parameter logic [31:0] SEED      = 32'hACE1_2025,
  parameter logic [31:0] TAPS      = 32'h8020_0003,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic        start,
  split_12_sampler_if.master bus,
  output logic [7:0]  tries,
  output logic        busy,
  output logic        fail
);

  localparam logic [7:0] LP_LAST_TRY = 8'(MAX_TRIES - 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_CHECK, S_HOLD, S_FAIL} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_lfsr, w_lfsr_nxt;
  logic [7:0]  r_var_20, w_var_20_nxt;
  logic [7:0]  r_var_41, w_var_41_nxt;
  logic [7:0]  r_tries, w_tries_nxt;
  logic        r_fail, w_fail_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_busy, w_busy_nxt;

  logic [31:0] w_lfsr_step;
  logic        w_accept;
  logic        w_handshake;

  // Galois right-shift step
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);

  // Both constraints spelled out so the acceptance test mirrors the checker
  assign w_accept = (r_var_20 != 8'h00) && ((r_var_20 != 8'h00) || (r_var_41 != 8'h00));

  assign w_handshake = r_valid && bus.out_ready;

  // Next-state and datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_var_20_nxt = r_var_20;
    w_var_41_nxt = r_var_41;
    w_tries_nxt  = r_tries;
    w_fail_nxt   = r_fail;
    unique case (r_state)
      S_IDLE: begin
        // Seed load wins over a simultaneous start
        if (seed_load) begin
          w_lfsr_nxt = (seed_in == 32'h0) ? SEED : seed_in;
        end else if (start) begin
          w_tries_nxt = 8'h00;
          w_fail_nxt  = 1'b0;
          w_state_nxt = S_GEN;
        end
      end
      S_GEN: begin
        w_lfsr_nxt   = w_lfsr_step;
        w_var_20_nxt = w_lfsr_step[7:0];
        w_var_41_nxt = w_lfsr_step[15:8];
        w_state_nxt  = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) begin
          w_state_nxt = S_HOLD;
        end else if (r_tries == LP_LAST_TRY) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = S_FAIL;
        end else begin
          w_tries_nxt = r_tries + 8'h01;
          w_state_nxt = S_GEN;
        end
      end
      S_HOLD: begin
        if (w_handshake) begin
          if (start) begin
            w_tries_nxt = 8'h00;
            w_state_nxt = S_GEN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        // LFSR is left alone so a retry continues the sequence
        if (start) begin
          w_fail_nxt  = 1'b0;
          w_tries_nxt = 8'h00;
          w_state_nxt = S_GEN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_valid_nxt = (w_state_nxt == S_HOLD);
    w_busy_nxt  = (w_state_nxt == S_GEN) || (w_state_nxt == S_CHECK) || (w_state_nxt == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_var_20 <= 8'h00;
      r_var_41 <= 8'h00;
      r_tries  <= 8'h00;
      r_fail   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_var_20 <= w_var_20_nxt;
      r_var_41 <= w_var_41_nxt;
      r_tries  <= w_tries_nxt;
      r_fail   <= w_fail_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.var_20    = r_var_20;
  assign bus.var_41    = r_var_41;
  assign tries         = r_tries;
  assign busy          = r_busy;
  assign fail          = r_fail;

endmodule

// File: tb/tb_split_12_sampler.sv
// Directed bench for split_12_sampler: reset, seeding, rejection, FAIL path,
// backpressure, mid-request reset and a long randomised-ready soak.
module tb_split_12_sampler;

  localparam logic [31:0] LP_SEED = 32'hACE1_2025;
  localparam logic [31:0] LP_TAPS = 32'h8020_0003;
  localparam int          LP_SOAK = 10000;

  logic        clk;
  logic        rst_n;
  logic        seed_load, seed_load1;
  logic [31:0] seed_in, seed_in1;
  logic        start, start1;
  logic [7:0]  tries, tries1;
  logic        busy, busy1, fail, fail1;

  int vectors;
  int errors;

  split_12_sampler_if if0 ();
  split_12_sampler_if if1 ();

  split_12_sampler u_dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .bus(if0.master), .tries(tries), .busy(busy), .fail(fail)
  );

  split_12_sampler #(.MAX_TRIES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load1), .seed_in(seed_in1),
    .start(start1), .bus(if1.master), .tries(tries1), .busy(busy1), .fail(fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on the default instance: check latency, sample and handshake
  task automatic req(input string tag, input logic [7:0] e20, input logic [7:0] e41,
                     input logic [7:0] et, input int elat);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!if0.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_v20"}, 32'(if0.var_20), 32'(e20));
    chk({tag, "_v41"}, 32'(if0.var_41), 32'(e41));
    chk({tag, "_tries"}, 32'(tries), 32'(et));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    chk({tag, "_vdrop"}, 32'(if0.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(if0.out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_v20"}, 32'(if0.var_20), 32'd0);
    chk({tag, "_v41"}, 32'(if0.var_41), 32'd0);
    chk({tag, "_tries"}, 32'(tries), 32'd0);
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LP_TAPS : 32'h0);
  endfunction

  initial begin
    logic [31:0] m_lfsr;
    logic [7:0]  a, b;
    logic        v, rdy;
    int          transfers, cyc;

    vectors = 0;
    errors  = 0;
    rst_n = 1'b0;
    seed_load = 1'b0; seed_in = 32'h0; start = 1'b0;
    seed_load1 = 1'b0; seed_in1 = 32'h0; start1 = 1'b0;
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // Sequence from SEED: 0xD6509011 then 0xEB08480B
    req("seedA1", 8'h11, 8'h90, 8'h00, 3);
    req("seedA2", 8'h0B, 8'h48, 8'h00, 3);

    // Seed 0x200: 0x100 rejected (var_20=0), 0x080 accepted
    seed_load = 1'b1; seed_in = 32'h0000_0200;
    tick();
    seed_load = 1'b0;
    req("rej1", 8'h80, 8'h00, 8'h01, 5);

    // Zero seed behaves like SEED
    seed_load = 1'b1; seed_in = 32'h0;
    tick();
    seed_load = 1'b0;
    req("zseed1", 8'h11, 8'h90, 8'h00, 3);
    req("zseed2", 8'h0B, 8'h48, 8'h00, 3);

    // Backpressure: next LFSR 0xF5A42406
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("bp_valid0", 32'(if0.out_valid), 32'd1);
    chk("bp_v20_0", 32'(if0.var_20), 32'h06);
    chk("bp_v41_0", 32'(if0.var_41), 32'h24);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(if0.out_valid), 32'd1);
      chk("bp_v20", 32'(if0.var_20), 32'h06);
      chk("bp_v41", 32'(if0.var_41), 32'h24);
    end
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_after", 32'(if0.out_valid), 32'd0);
      tick();
    end

    // Reset during CHECK
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_zero("rst_check");
    rst_n = 1'b1;
    req("rc_after", 8'h11, 8'h90, 8'h00, 3);

    // Reset during HOLD
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rh_valid", 32'(if0.out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_zero("rst_hold");
    rst_n = 1'b1;
    req("rh_after", 8'h11, 8'h90, 8'h00, 3);

    // FAIL path, MAX_TRIES=2: 0x200 and 0x100 both rejected
    seed_load1 = 1'b1; seed_in1 = 32'h0000_0400;
    tick();
    seed_load1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      chk("f_valid", 32'(if1.out_valid), 32'd0);
      chk("f_fail_early", 32'(fail1), 32'd0);
      tick();
    end
    chk("f_fail", 32'(fail1), 32'd1);
    chk("f_busy", 32'(busy1), 32'd0);
    chk("f_valid5", 32'(if1.out_valid), 32'd0);
    tick();
    chk("f_sticky", 32'(fail1), 32'd1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("f_clear", 32'(fail1), 32'd0);
    chk("f_rebusy", 32'(busy1), 32'd1);
    tick();
    tick();
    chk("f_retry_valid", 32'(if1.out_valid), 32'd1);
    chk("f_retry_v20", 32'(if1.var_20), 32'h80);
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;

    // Soak: start held high, random ready, every transfer checked against a model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_lfsr = LP_SEED;
    transfers = 0;
    cyc = 0;
    start = 1'b1;
    while (transfers < LP_SOAK && cyc < 80000) begin
      v = if0.out_valid;
      a = if0.var_20;
      b = if0.var_41;
      rdy = 1'($urandom_range(0, 1));
      if0.out_ready = rdy;
      tick();
      cyc++;
      if (v && rdy) begin
        m_lfsr = step(m_lfsr);
        while (m_lfsr[7:0] == 8'h00) m_lfsr = step(m_lfsr);
        chk("soak_v20", 32'(a), 32'(m_lfsr[7:0]));
        chk("soak_v41", 32'(b), 32'(m_lfsr[15:8]));
        chk("soak_nz", 32'(a != 8'h00), 32'd1);
        transfers++;
      end
    end
    start = 1'b0;
    if0.out_ready = 1'b0;
    chk("soak_count", 32'(transfers), 32'(LP_SOAK));
    chk("soak_fail", 32'(fail), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
